// File: rtl/lms_coeff_updater.sv
// lms_coeff_updater: sign-preserving LMS coefficient engine for a transposed FIR.
// Each accepted sample shifts the delay line and latches the saturated error.
// Taps are then adapted one per cycle into a shadow bank, and the full set is
// committed to the coeffs bus in a single cycle, so the FIR never sees a mixed set.
module lms_coeff_updater #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 14,
    parameter int TAPS     = 8,
    parameter int MU_SHIFT = 6
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_valid,
    input  logic [WIDTH-1:0]             din,
    input  logic [WIDTH-1:0]             i_desired,
    input  logic [WIDTH-1:0]             i_y,
    input  logic                         i_freeze,
    input  logic                         i_clear,
    output logic                         o_ready,
    output logic [TAPS-1:0][WIDTH-1:0]   coeffs,
    output logic [WIDTH-1:0]             o_err,
    output logic                         o_done
);

    // Tap index width and fixed constants used by the datapath.
    localparam int              IW       = $clog2(TAPS);
    localparam int              SHIFT    = FRAC + MU_SHIFT;
    localparam logic [IW-1:0]   LAST_IDX = IW'(TAPS - 1);
    localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
    localparam logic [IW-1:0]   IDX_ZERO = {IW{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Clamp a WIDTH+1 bit signed value into the WIDTH bit signed range.
    function automatic logic [WIDTH-1:0] sat_w(input logic [WIDTH:0] v);
        logic [WIDTH-1:0] r;
        if (v[WIDTH] == v[WIDTH-1]) begin
            r = v[WIDTH-1:0];
        end else if (v[WIDTH]) begin
            r = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            r = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // Clamp a full-product-width signed value into WIDTH+1 bits.
    function automatic logic [WIDTH:0] sat_w1(input logic [2*WIDTH-1:0] v);
        logic [WIDTH:0] r;
        if ((&v[2*WIDTH-1:WIDTH]) || (~|v[2*WIDTH-1:WIDTH])) begin
            r = v[WIDTH:0];
        end else if (v[2*WIDTH-1]) begin
            r = {1'b1, {WIDTH{1'b0}}};
        end else begin
            r = {1'b0, {WIDTH{1'b1}}};
        end
        return r;
    endfunction

    state_t                        state_q;
    logic [IW-1:0]                 idx_q;
    logic                          ready_q;
    logic                          done_q;
    logic [WIDTH-1:0]              err_q;
    logic [TAPS-1:0][WIDTH-1:0]    x_q;
    logic [TAPS-1:0][WIDTH-1:0]    shadow_q;
    logic [TAPS-1:0][WIDTH-1:0]    coeffs_q;

    logic                          accept_s;
    logic signed [WIDTH:0]         diff_s;
    logic [WIDTH-1:0]              err_d;
    logic [WIDTH-1:0]              tap_x_s;
    logic [WIDTH-1:0]              tap_c_s;
    logic signed [2*WIDTH-1:0]     prod_s;
    logic signed [2*WIDTH-1:0]     inc_full_s;
    logic signed [WIDTH:0]         inc_s;
    logic signed [WIDTH:0]         sum_s;
    logic [WIDTH-1:0]              upd_d;

    // Error path: d - y at WIDTH+1 bits, then clamped; only used on acceptance.
    always_comb begin
        accept_s = 1'b0;
        if (i_valid && (state_q == ST_IDLE)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        diff_s = $signed({i_desired[WIDTH-1], i_desired}) - $signed({i_y[WIDTH-1], i_y});
        err_d  = sat_w(diff_s);
    end

    // Per-tap update: floor-rounded scaled product added to the shadow tap with saturation.
    always_comb begin
        tap_x_s    = x_q[idx_q];
        tap_c_s    = shadow_q[idx_q];
        prod_s     = $signed({{WIDTH{err_q[WIDTH-1]}}, err_q})
                   * $signed({{WIDTH{tap_x_s[WIDTH-1]}}, tap_x_s});
        inc_full_s = prod_s >>> SHIFT;
        inc_s      = $signed(sat_w1(inc_full_s));
        sum_s      = $signed({tap_c_s[WIDTH-1], tap_c_s}) + inc_s;
        upd_d      = sat_w(sum_s);
    end

    // Control FSM: sequencing, tap index and the registered ready/done flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_ZERO;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else if (i_clear) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_ZERO;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (i_valid) begin
                        idx_q <= IDX_ZERO;
                        if (!i_freeze) begin
                            state_q <= ST_UPDATE;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b0;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= IDX_ZERO;
                        state_q <= ST_COMMIT;
                    end else begin
                        idx_q   <= idx_q + IDX_ONE;
                        state_q <= ST_UPDATE;
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= IDX_ZERO;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: delay line, error register, shadow bank and committed coefficient set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= ZERO_W;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k]      <= ZERO_W;
                shadow_q[k] <= ZERO_W;
                coeffs_q[k] <= ZERO_W;
            end
        end else if (i_clear) begin
            err_q <= ZERO_W;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k]      <= ZERO_W;
                shadow_q[k] <= ZERO_W;
                coeffs_q[k] <= ZERO_W;
            end
        end else if (accept_s) begin
            // Shift the delay line, latch the error and seed the shadow from the live set.
            for (int k = TAPS - 1; k > 0; k--) begin
                x_q[k] <= x_q[k-1];
            end
            x_q[0]   <= din;
            err_q    <= err_d;
            shadow_q <= coeffs_q;
        end else if (state_q == ST_UPDATE) begin
            shadow_q[idx_q] <= upd_d;
        end else if (state_q == ST_COMMIT) begin
            coeffs_q <= shadow_q;
        end else begin
            err_q <= err_q;
        end
    end

    assign o_ready = ready_q;
    assign o_done  = done_q;
    assign o_err   = err_q;
    assign coeffs  = coeffs_q;

endmodule

// File: tb/tb_lms_coeff_updater.sv
// Testbench for lms_coeff_updater: directed scenarios plus randomized traffic,
// all checked every cycle against a set-at-a-time behavioural model.
module tb_lms_coeff_updater;

    localparam int WIDTH    = 16;
    localparam int FRAC     = 14;
    localparam int TAPS     = 8;
    localparam int MU_SHIFT = 6;

    logic                       clk       = 1'b0;
    logic                       rstn      = 1'b0;
    logic                       i_valid   = 1'b0;
    logic                       i_freeze  = 1'b0;
    logic                       i_clear   = 1'b0;
    logic [WIDTH-1:0]           din       = 16'h0000;
    logic [WIDTH-1:0]           i_desired = 16'h0000;
    logic [WIDTH-1:0]           i_y       = 16'h0000;
    logic                       o_ready;
    logic                       o_done;
    logic [WIDTH-1:0]           o_err;
    logic [TAPS-1:0][WIDTH-1:0] coeffs;

    int checks = 0;
    int errors = 0;

    // Model state: whole-set view, new set computed at acceptance and released after TAPS+1 edges.
    int exp_x[TAPS];
    int exp_c[TAPS];
    int pend[TAPS];
    int exp_err   = 0;
    bit exp_ready = 1'b1;
    bit exp_done  = 1'b0;
    int busy      = 0;

    lms_coeff_updater #(
        .WIDTH(WIDTH), .FRAC(FRAC), .TAPS(TAPS), .MU_SHIFT(MU_SHIFT)
    ) dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .din(din),
        .i_desired(i_desired), .i_y(i_y), .i_freeze(i_freeze), .i_clear(i_clear),
        .o_ready(o_ready), .coeffs(coeffs), .o_err(o_err), .o_done(o_done)
    );

    always #5 clk = ~clk;

    function automatic int sat(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return int'(hi);
        else if (v < lo) return int'(lo);
        else return int'(v);
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h (%0d) expected 0x%04h (%0d) at %0t",
                     name, act, $signed(act), exp, $signed(exp), $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            exp_x[k] = 0;
            exp_c[k] = 0;
            pend[k]  = 0;
        end
        exp_err   = 0;
        exp_ready = 1'b1;
        exp_done  = 1'b0;
        busy      = 0;
    endtask

    task automatic model_step();
        int  e;
        longint p;
        if (!rstn || i_clear) begin
            model_reset();
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                for (int k = 0; k < TAPS; k++) exp_c[k] = pend[k];
                exp_ready = 1'b1;
                exp_done  = 1'b1;
            end else begin
                exp_done = 1'b0;
            end
        end else begin
            exp_done = 1'b0;
            if (i_valid) begin
                for (int k = TAPS - 1; k > 0; k--) exp_x[k] = exp_x[k-1];
                exp_x[0] = int'($signed(din));
                e = sat(longint'($signed(i_desired)) - longint'($signed(i_y)), WIDTH);
                exp_err = e;
                if (!i_freeze) begin
                    for (int k = 0; k < TAPS; k++) begin
                        p = longint'(e) * longint'(exp_x[k]);
                        pend[k] = sat(longint'(exp_c[k]) + longint'(sat(p >>> (FRAC + MU_SHIFT), WIDTH + 1)), WIDTH);
                    end
                    busy      = TAPS + 1;
                    exp_ready = 1'b0;
                end
            end
        end
    endtask

    // Model advances on every clock edge and on asynchronous reset assertion.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < TAPS; k++) begin
                chk($sformatf("cyc_coeffs%0d", k), coeffs[k], WIDTH'(exp_c[k]));
            end
            chk("cyc_err",   o_err, WIDTH'(exp_err));
            chk("cyc_ready", {{(WIDTH-1){1'b0}}, o_ready}, {{(WIDTH-1){1'b0}}, exp_ready});
            chk("cyc_done",  {{(WIDTH-1){1'b0}}, o_done},  {{(WIDTH-1){1'b0}}, exp_done});
        end
    end

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] d,
                        input logic [WIDTH-1:0] y, input logic frz);
        @(negedge clk);
        din = x; i_desired = d; i_y = y; i_freeze = frz; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0; i_freeze = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; i_valid = 1'b0; i_clear = 1'b0; i_freeze = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [WIDTH-1:0] w;
        case ($urandom_range(0, 3))
            0:       w = 16'h7FFF;
            1:       w = 16'h8000;
            default: w = WIDTH'($urandom);
        endcase
        return w;
    endfunction

    initial begin
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        chk("rst_ready", {{(WIDTH-1){1'b0}}, o_ready}, 16'd1);
        chk("rst_err", o_err, 16'h0000);

        // Single update: only coeffs[0] moves, by 64, after TAPS+2 cycles.
        send(16'h2000, 16'h2000, 16'h0000, 1'b0);
        chk("s2_err", o_err, 16'h2000);
        for (int t = 1; t <= 9; t++) begin
            chk("s2_busy_ready", {{(WIDTH-1){1'b0}}, o_ready}, 16'd0);
            chk("s2_c0_hold", coeffs[0], 16'd0);
            @(negedge clk);
        end
        chk("s2_c0", coeffs[0], 16'd64);
        chk("s2_c1", coeffs[1], 16'd0);
        chk("s2_done", {{(WIDTH-1){1'b0}}, o_done}, 16'd1);
        chk("s2_ready", {{(WIDTH-1){1'b0}}, o_ready}, 16'd1);
        chk("model_s2_c0", WIDTH'(exp_c[0]), 16'd64);
        @(negedge clk);
        chk("s2_done_once", {{(WIDTH-1){1'b0}}, o_done}, 16'd0);

        // Freeze: error and delay line move, coefficients do not.
        send(16'h4000, 16'h1000, 16'h0000, 1'b1);
        chk("frz_err", o_err, 16'h1000);
        chk("frz_ready", {{(WIDTH-1){1'b0}}, o_ready}, 16'd1);
        chk("frz_c0", coeffs[0], 16'd64);
        chk("frz_done", {{(WIDTH-1){1'b0}}, o_done}, 16'd0);
        send(16'h0000, 16'h2000, 16'h0000, 1'b0);
        repeat (9) @(negedge clk);
        chk("frz_next_c0", coeffs[0], 16'd64);
        chk("frz_next_c1", coeffs[1], 16'd128);
        chk("frz_next_c2", coeffs[2], 16'd64);
        chk("model_frz_c2", WIDTH'(exp_c[2]), 16'd64);

        // Asynchronous reset in the middle of an update.
        send(16'h1000, 16'h2000, 16'h0000, 1'b0);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_c0", coeffs[0], 16'd0);
        chk("arst_c1", coeffs[1], 16'd0);
        chk("arst_err", o_err, 16'h0000);
        chk("arst_ready", {{(WIDTH-1){1'b0}}, o_ready}, 16'd1);
        chk("arst_done", {{(WIDTH-1){1'b0}}, o_done}, 16'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Floor rounding: e = -1, x = 1 gives inc = -1.
        send(16'h0001, 16'h0000, 16'h0001, 1'b0);
        chk("floor_err", o_err, 16'hFFFF);
        repeat (9) @(negedge clk);
        chk("floor_c0", coeffs[0], 16'hFFFF);
        chk("floor_done", {{(WIDTH-1){1'b0}}, o_done}, 16'd1);

        // Saturation of both error and coefficient.
        do_reset();
        for (int s = 1; s <= 35; s++) begin
            send(16'h7FFF, 16'h7FFF, 16'h8000, 1'b0);
            chk("sat_err", o_err, 16'h7FFF);
            repeat (9) @(negedge clk);
            if (s == 32) chk("sat_c0_32", coeffs[0], 16'd32736);
            if (s >= 33) chk("sat_c0_clamp", coeffs[0], 16'h7FFF);
        end

        // Busy: a valid during UPDATE is ignored.
        do_reset();
        send(16'h2000, 16'h2000, 16'h0000, 1'b0);
        @(negedge clk);
        din = 16'h7000; i_desired = 16'h7000; i_y = 16'h0000; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("busy_c0", coeffs[0], 16'd64);
        chk("busy_c1", coeffs[1], 16'd0);
        chk("busy_err", o_err, 16'h2000);
        chk("busy_done", {{(WIDTH-1){1'b0}}, o_done}, 16'd1);

        // Clear mid-update discards the in-flight set.
        do_reset();
        send(16'h2000, 16'h2000, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        chk("clr_c0", coeffs[0], 16'd0);
        chk("clr_err", o_err, 16'h0000);
        chk("clr_ready", {{(WIDTH-1){1'b0}}, o_ready}, 16'd1);
        chk("clr_done", {{(WIDTH-1){1'b0}}, o_done}, 16'd0);
        repeat (5) @(negedge clk);
        chk("clr_no_done", {{(WIDTH-1){1'b0}}, o_done}, 16'd0);
        chk("clr_c0_late", coeffs[0], 16'd0);

        // Randomized traffic, including busy-time valids, freezes and clears.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            i_valid   = ($urandom_range(0, 1) == 1);
            i_freeze  = ($urandom_range(0, 3) == 0);
            i_clear   = ($urandom_range(0, 199) == 0);
            din       = rnd_word();
            i_desired = rnd_word();
            i_y       = rnd_word();
        end
        @(negedge clk);
        i_valid = 1'b0; i_clear = 1'b0; i_freeze = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lms_coeff_updater.md
# lms_coeff_updater

Adaptive coefficient engine for the transposed FIR. Each accepted sample updates a signed fixed-point coefficient set with the sign-preserving LMS rule c[k] += 2^-MU_SHIFT · e · x[n-k]. The updated set is presented on a packed bus that connects directly to the FIR's `coeffs` input. Updates are time-multiplexed one tap per cycle into a shadow bank, and the whole set is committed atomically, so the FIR never sees a partially updated set.

## Interface

**Parameters**
- WIDTH, 16, sample, coefficient and error word width (signed two's complement)
- FRAC, 14, fractional bits of every WIDTH-bit word
- TAPS, 8, number of coefficients (≥ 2)
- MU_SHIFT, 6, step size µ = 2^-MU_SHIFT

**Ports**
- clk  in  1  single clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- i_valid  in  1  sample strobe; accepted when i_valid && o_ready
- din  in  WIDTH  x[n], the same sample fed to the FIR
- i_desired  in  WIDTH  d[n], reference signal
- i_y  in  WIDTH  y[n], FIR output for x[n]
- i_freeze  in  1  sampled at acceptance; 1 = shift data and compute error, but do not adapt
- i_clear  in  1  synchronous clear of all state; highest priority after reset
- o_ready  out  1  high in IDLE only
- coeffs  out  [TAPS-1:0][WIDTH-1:0]  committed set; coeffs[k] weights x[n-k]
- o_err  out  WIDTH  last saturated error e = d − y
- o_done  out  1  one-cycle pulse in the cycle the new set first appears on coeffs

## Operation

- **State:**
  - delay line x[0..TAPS-1]
  - shadow[0..TAPS-1]
  - coeffs[0..TAPS-1]
  - tap index idx (clog2(TAPS) bits)
  - error register
  - FSM {IDLE, UPDATE, COMMIT}
- **Reset:** x, shadow, coeffs, o_err = 0; o_done = 0; state IDLE, so o_ready = 1.
- **IDLE, on acceptance:**
  - shift x[k] ← x[k-1] and x[0] ← din
  - e ← sat_W(d − y), computed at WIDTH+1 bits
  - o_err ← e
  - shadow ← coeffs
  - idx ← 0
  - if i_freeze = 0, go to UPDATE; else stay in IDLE (no o_done).
- **UPDATE, each cycle for tap idx:**
  - p = e · x[idx], full 2·WIDTH signed product
  - inc = p >>> (FRAC + MU_SHIFT), arithmetic shift, i.e. floor rounding
  - shadow[idx] ← sat_W(shadow[idx] + inc), summed at WIDTH+1 bits after truncating inc to WIDTH+1 bits with saturation
  - idx++; when idx = TAPS−1, go to COMMIT.
  - The tap uses the post-shift delay line, so x[0] is the new din.
- **COMMIT:** coeffs ← shadow, o_done ← 1, go to IDLE.
- **sat_W:** clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. There is no wrap-around anywhere.
- **i_valid outside IDLE:** ignored. The sample is not queued and state is unaffected.
- **i_clear (any state):** on the next edge, x, shadow, coeffs, o_err and idx are zeroed, o_done = 0, state = IDLE. It overrides a simultaneous i_valid, and an in-flight update is discarded (no o_done).
- **Reset mid-operation:** same end state as the reset values, applied asynchronously.

## Timing

- Sample accepted at edge T (o_ready = 1, i_valid = 1). From T+1: o_err holds the new error, o_ready = 0, state UPDATE.
- UPDATE occupies cycles T+1 … T+TAPS, one tap per cycle; COMMIT is cycle T+TAPS+1.
- In cycle T+TAPS+2: the new coeffs are visible, o_done = 1 for exactly this cycle, o_ready = 1.
- coeffs is constant from T through T+TAPS+1.
- Throughput: one adapting sample per TAPS+2 cycles. A frozen sample takes 1 cycle and o_ready stays high.
- All outputs are registered, with no combinational path from input to output.

## Test plan

All values use defaults (1.0 = 16384, TAPS = 8).

1. **Reset:** assert rstn = 0 mid-UPDATE → coeffs = 0, o_err = 0, o_done = 0, o_ready = 1 immediately, without waiting for clk.
2. **Single update:** from reset, din = 0x2000, i_desired = 0x2000, i_y = 0 →
   - o_err = 0x2000 at T+1
   - o_ready low T+1..T+9
   - at T+10: coeffs[0] = 64, coeffs[1..7] = 0, o_done pulses once
   - coeffs unchanged before T+10.
3. **Floor rounding:** from reset, din = 0x0001, i_desired = 0, i_y = 0x0001 → e = −1 and inc = −1, so coeffs[0] = 0xFFFF after commit.
4. **Saturation:**
   - 33 accepted samples of din = 0x7FFF, i_desired = 0x7FFF, i_y = 0x8000 → o_err = 0x7FFF on every sample
   - coeffs[0] = 32736 after 32 samples and 0x7FFF after 33, with no wrap.
   - Subsequent samples keep coeffs[0] = 0x7FFF.
5. **Busy and clear:**
   - i_valid pulsed at T+3 during UPDATE with a different din → ignored; the final coeffs match scenario 2.
   - Separately, i_clear at T+4 → all outputs 0 at T+5, o_ready = 1, no o_done.
6. **Freeze:** after scenario 2, accept a sample with i_freeze = 1 and din = 0x4000 →
   - o_err updates at T+1, o_ready stays 1
   - coeffs remain {64, 0, …}, no o_done
   - x[1] now holds 0x2000, checked by a following unfrozen update.
